// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared constants and types for the video-in write path
// Shared by the packing FIFO and the Wishbone write master.
package video_in_pkg;

  localparam int DATA_SIZE   = 32;
  localparam int NB_PACK     = 16;
  localparam int ADDR_SIZE   = 32;
  localparam int FRAME_WORDS = 76800;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SETTLE
  } wbm_state_t;

endpackage

// File: rtl/video_in_addr_gen.sv
// rtl/video_in_addr_gen.sv - frame word counter, write address and frame_done pulse
// Reloads the address from frame_base on the first burst of each frame.
module video_in_addr_gen
  import video_in_pkg::*;
#(
  parameter int WORDS_PER_FRAME = FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 frame_start_i,
  input  logic                 word_ack_i,
  input  logic [ADDR_SIZE-1:0] frame_base_i,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 first_word_o,
  output logic                 frame_done_o
);

  localparam int FC_W = $clog2(WORDS_PER_FRAME) + 1;

  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_last;

  assign frame_last = (frame_cnt_q == FC_W'(WORDS_PER_FRAME - 1));

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    if (frame_start_i) begin
      addr_d = frame_base_i;
    end else if (word_ack_i) begin
      addr_d = addr_q + ADDR_SIZE'(4);
    end
    // Wrapping the counter to zero is what arms the next frame_base reload.
    if (word_ack_i) begin
      if (frame_last) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      frame_cnt_q  <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr_o       = addr_q;
  assign first_word_o = (frame_cnt_q == '0);
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/video_in_wb_master.sv
// rtl/video_in_wb_master.sv - pops NB_PACK-word packets from the FIFO into locked Wishbone write bursts
// Each word is REQ until ack, then one SETTLE cycle to cover the FIFO read latency.
module video_in_wb_master #(
  parameter int DATA_SIZE   = video_in_pkg::DATA_SIZE,
  parameter int NB_PACK     = video_in_pkg::NB_PACK,
  parameter int FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
  input  logic                               clk,
  input  logic                               nRST,
  input  logic                               enable,
  input  logic [video_in_pkg::ADDR_SIZE-1:0] frame_base,
  input  logic [DATA_SIZE-1:0]               fifo_data,
  input  logic                               nb_pack_available,
  output logic                               r_ack,
  output logic                               wb_cyc_o,
  output logic                               wb_stb_o,
  output logic                               wb_we_o,
  output logic [video_in_pkg::ADDR_SIZE-1:0] wb_adr_o,
  output logic [DATA_SIZE-1:0]               wb_dat_o,
  output logic [3:0]                         wb_sel_o,
  input  logic                               wb_ack_i,
  output logic                               frame_done
);

  import video_in_pkg::*;

  localparam int BURST_W = $clog2(NB_PACK) + 1;

  wbm_state_t         state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               word_ack;
  logic               frame_start;
  logic               first_word;
  logic               burst_last;

  assign word_ack   = wb_ack_i & wb_stb_o;
  assign burst_last = (burst_cnt_q == BURST_W'(NB_PACK - 1));

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    frame_start = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && nb_pack_available) begin
          state_d     = REQ;
          frame_start = first_word;
        end
      end
      REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (wb_ack_i) begin
          if (burst_last) begin
            burst_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
            state_d     = SETTLE;
          end
        end
      end
      SETTLE: begin
        wb_cyc_o = 1'b1;
        state_d  = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  video_in_addr_gen #(
    .WORDS_PER_FRAME(FRAME_WORDS)
  ) u_addr_gen (
    .clk          (clk),
    .nRST         (nRST),
    .frame_start_i(frame_start),
    .word_ack_i   (word_ack),
    .frame_base_i (frame_base),
    .addr_o       (wb_adr_o),
    .first_word_o (first_word),
    .frame_done_o (frame_done)
  );

  assign r_ack    = word_ack;
  assign wb_we_o  = wb_cyc_o;
  assign wb_sel_o = 4'hF;
  assign wb_dat_o = fifo_data;

endmodule

// File: tb/tb_video_in_wb_master.sv
// tb/tb_video_in_wb_master.sv - directed bench for video_in_wb_master with FIFO and slave models
module tb_video_in_wb_master;
  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] frame_base = 32'h0;
  logic [31:0] fifo_data = 32'h0;
  logic        nb_pack_available = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        r_ack, wb_cyc_o, wb_stb_o, wb_we_o, frame_done;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  logic [31:0] mem [256];
  int          rd = 0, wr = 0, ack_delay = 0, wait_cnt = 0;
  logic        pop_s = 1'b0;

  int          n = 0, cyc_cnt = 0, rack_cnt = 0, fd_cnt = 0, cycle = 0;
  int          ack_cycle = 0, fd_cycle = 0, stab_err = 0, ctl_err = 0;
  logic [31:0] wr_adr [64];
  logic [31:0] wr_dat [64];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;
  int          checks = 0, errors = 0;

  video_in_wb_master #(
    .DATA_SIZE  (32),
    .NB_PACK    (NB),
    .FRAME_WORDS(32)
  ) dut (
    .clk              (clk),
    .nRST             (nRST),
    .enable           (enable),
    .frame_base       (frame_base),
    .fifo_data        (fifo_data),
    .nb_pack_available(nb_pack_available),
    .r_ack            (r_ack),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_adr_o         (wb_adr_o),
    .wb_dat_o         (wb_dat_o),
    .wb_sel_o         (wb_sel_o),
    .wb_ack_i         (wb_ack_i),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model (pop at T, new head visible at T+2) and Wishbone slave with ack_delay wait states
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    forever begin
      @(negedge clk);
      pop_s = r_ack;
      @(posedge clk);
      #1;
      fifo_data = mem[rd[7:0]];
      if (!nRST) rd = 0;
      else if (pop_s) rd = rd + 1;
      nb_pack_available = ((wr - rd) >= NB);
      if (wb_stb_o) begin
        if (wait_cnt >= ack_delay) begin
          wb_ack_i = 1'b1;
          wait_cnt = 0;
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wb_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cycle = cycle + 1;
      if (wb_cyc_o) cyc_cnt = cyc_cnt + 1;
      if (r_ack) rack_cnt = rack_cnt + 1;
      if (frame_done) begin
        fd_cnt   = fd_cnt + 1;
        fd_cycle = cycle;
      end
      if (wb_we_o !== wb_cyc_o || wb_sel_o !== 4'hF) ctl_err = ctl_err + 1;
      if (prev_wait && wb_stb_o && (wb_adr_o !== prev_adr || wb_dat_o !== prev_dat))
        stab_err = stab_err + 1;
      if (wb_stb_o && wb_ack_i) begin
        if (n < 64) begin
          wr_adr[n] = wb_adr_o;
          wr_dat[n] = wb_dat_o;
        end
        n = n + 1;
        ack_cycle = cycle;
      end
      prev_wait = wb_stb_o && !wb_ack_i;
      prev_adr  = wb_adr_o;
      prev_dat  = wb_dat_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n = 0; cyc_cnt = 0; rack_cnt = 0; fd_cnt = 0; stab_err = 0; ctl_err = 0;
  endtask

  task automatic wait_acks(input int target, input string tag);
    int budget = 0;
    while (n < target && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check(tag, 32'(n), 32'(target));
  endtask

  task automatic check_words(input string tag, input int cnt, input logic [31:0] base,
                             input logic [31:0] first_dat);
    for (int k = 0; k < cnt; k++) begin
      check({tag, "_adr"}, wr_adr[k], base + 32'(4 * k));
      check({tag, "_dat"}, wr_dat[k], first_dat + 32'(k));
    end
  endtask

  initial begin
    // Reset held with data available: everything quiet
    frame_base = 32'h1000;
    enable     = 1'b1;
    wr         = 16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wb_cyc_o), 32'h0);
    check("rst_stb", 32'(wb_stb_o), 32'h0);
    check("rst_we", 32'(wb_we_o), 32'h0);
    check("rst_rack", 32'(r_ack), 32'h0);
    check("rst_fdone", 32'(frame_done), 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);

    enable = 1'b0;
    nRST   = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_enable", 32'(wb_stb_o), 32'h0);
    clear_stats();
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("first_stb", 32'(wb_stb_o), 32'h1);
    check("first_adr", wb_adr_o, 32'h1000);

    // Burst 1: zero-wait slave
    wait_acks(16, "b1_acks");
    repeat (3) @(negedge clk);
    check_words("b1", 16, 32'h1000, 32'h1);
    check("b1_rack", 32'(rack_cnt), 32'd16);
    check("b1_cyc_len", 32'(cyc_cnt), 32'd31);
    check("b1_fdone", 32'(fd_cnt), 32'd0);
    check("b1_ctl", 32'(ctl_err), 32'd0);

    // Burst 2: three wait states per word, frame_base changed mid-burst, frame ends
    clear_stats();
    ack_delay = 3;
    wr        = 32;
    wait_acks(4, "b2_early");
    frame_base = 32'h8000;
    wait_acks(16, "b2_acks");
    repeat (3) @(negedge clk);
    check_words("b2", 16, 32'h1040, 32'd17);
    check("b2_rack", 32'(rack_cnt), 32'd16);
    check("b2_cyc_len", 32'(cyc_cnt), 32'd79);
    check("b2_stable", 32'(stab_err), 32'd0);
    check("b2_fdone_cnt", 32'(fd_cnt), 32'd1);
    check("b2_fdone_time", 32'(fd_cycle - ack_cycle), 32'd1);

    // Burst 3: new frame starts at the updated base
    clear_stats();
    ack_delay = 0;
    wr        = 48;
    wait_acks(16, "b3_acks");
    repeat (3) @(negedge clk);
    check_words("b3", 16, 32'h8000, 32'd33);
    check("b3_cyc_len", 32'(cyc_cnt), 32'd31);
    check("b3_fdone", 32'(fd_cnt), 32'd0);

    // Burst 4: enable dropped mid-burst, two packets available
    clear_stats();
    wr = 80;
    wait_acks(5, "b4_early");
    enable = 1'b0;
    wait_acks(16, "b4_acks");
    repeat (40) @(negedge clk);
    check("b4_no_new_burst", 32'(n), 32'd16);
    check("b4_cyc_low", 32'(wb_cyc_o), 32'h0);
    check_words("b4", 16, 32'h8040, 32'd49);
    check("b4_fdone", 32'(fd_cnt), 32'd1);

    // Burst 5: reset after word 5, then restart from the new frame_base
    clear_stats();
    enable = 1'b1;
    wait_acks(5, "b5_acks");
    check_words("b5", 5, 32'h8000, 32'd65);
    @(posedge clk);
    #3;
    check("b5_cyc_before", 32'(wb_cyc_o), 32'h1);
    nRST = 1'b0;
    wr   = 0;
    #1;
    check("b5_async_cyc", 32'(wb_cyc_o), 32'h0);
    check("b5_async_stb", 32'(wb_stb_o), 32'h0);
    frame_base = 32'h2000;
    repeat (2) @(posedge clk);
    #2;
    nRST = 1'b1;
    clear_stats();
    wr = 16;
    wait_acks(16, "b6_acks");
    repeat (3) @(negedge clk);
    check_words("b6", 16, 32'h2000, 32'h1);
    check("b6_ctl", 32'(ctl_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_in_wb_master.md
# video_in_wb_master

Wishbone write master at the output end of the video-in packing FIFO. Waits until the FIFO holds a full packet (`nb_pack_available`), pops it word by word through the FIFO's `r_ack`/`data_out` read port, and writes each packet as one locked Wishbone cycle into a frame buffer in system memory. It tracks the write address across a frame, reloads the frame base address at every frame boundary, and signals frame completion to the video-in controller.

## Interface
Parameters:
- `DATA_SIZE`, 32, FIFO word width and Wishbone data width.
- `NB_PACK`, 16, words per packet/burst. Must match the FIFO threshold.
- `FRAME_WORDS`, 76800, 32-bit words per frame (640x480 8-bit pixels, 4 per word).

Ports:
- `clk`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; when low, no new burst starts.
- `frame_base`  in  32  byte address of the frame buffer, sampled at frame start.
- `fifo_data`  in  DATA_SIZE  FIFO `data_out`.
- `nb_pack_available`  in  1  FIFO holds at least NB_PACK words.
- `r_ack`  out  1  one-cycle pop strobe to the FIFO.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone control. `wb_we_o` is 1 whenever `wb_cyc_o` is 1.
- `wb_adr_o`  out  32  byte address, word aligned.
- `wb_dat_o`  out  DATA_SIZE  write data, driven combinationally from `fifo_data`.
- `wb_sel_o`  out  4  constant 4'hF.
- `wb_ack_i`  in  1  slave acknowledge.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame is acknowledged.

## Operation
- Reset values: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `r_ack` and `frame_done` are 0. `wb_adr_o` is 0. The frame word counter is 0. The state is IDLE. The next burst is the first word of a frame.
- IDLE: when `enable & nb_pack_available`, go to REQ. If this is the first word of a frame, load the address register from `frame_base`.
- REQ: `wb_cyc_o` = `wb_stb_o` = 1. Hold `wb_adr_o` and `wb_dat_o` stable until `wb_ack_i`. On ack:
  - `r_ack` = `wb_ack_i & wb_stb_o` in the same cycle (combinational).
  - Address += 4.
  - Burst counter += 1 and frame counter += 1.
  - If the burst counter reaches NB_PACK, go to IDLE and drop `wb_cyc_o` the next cycle. Otherwise go to SETTLE.
- SETTLE: exactly 1 cycle. `wb_cyc_o` = 1, `wb_stb_o` = 0. Covers the FIFO read latency. Then go to REQ.
- Frame end: when the frame counter reaches FRAME_WORDS on an ack:
  - Frame counter wraps to 0.
  - `frame_done` pulses in the following cycle.
  - The next burst reloads from `frame_base`.
  - FRAME_WORDS is a multiple of NB_PACK, so a frame always ends on a burst boundary.
- `enable` is checked only in IDLE. Dropping it mid-burst lets the burst complete.
- Counter widths:
  - Burst counter: $clog2(NB_PACK)+1 bits.
  - Frame counter: $clog2(FRAME_WORDS)+1 bits.
  - The address is a 32-bit adder; overflow wraps modulo 2^32 with no error.
- Reset mid-burst: all outputs return to reset values immediately (asynchronously). The partial packet already popped is lost. The FIFO is reset by the same `nRST`.

## Timing
- Pop latency: `r_ack` in cycle T makes the FIFO head advance at the end of T, and the new `fifo_data` is valid at T+2. SETTLE covers T+1, so `wb_stb_o` reasserts at T+2.
- Burst length with zero-wait-state slave: 2*NB_PACK-1 cycles of `wb_cyc_o` (31 for NB_PACK = 16).
- IDLE to the first `wb_stb_o`: 1 cycle after `nb_pack_available` is seen high.
- After the last ack, `wb_cyc_o` is low for at least 1 cycle before the next burst.
- `nb_pack_available` is not re-evaluated inside a burst: NB_PACK words are guaranteed present.

## Structure
- Shared package `video_in_pkg` holds:
  - Constants DATA_SIZE, NB_PACK, ADDR_SIZE and FRAME_WORDS, shared with the FIFO.
  - The state enum `wbm_state_t` {IDLE, REQ, SETTLE}.
- One natural sub-module, `video_in_addr_gen`: owns the frame counter, the address register, the `frame_base` reload and the `frame_done` generation. It is driven by the word-acked strobe and the frame-start strobe.

## Test plan
- Reset: hold `nRST` low with `nb_pack_available`=1 -> all outputs 0. After release, the first `wb_stb_o` appears 1 cycle after the first edge with `enable`=1.
- Zero-wait burst: FIFO preloaded with 0x01..0x10, `frame_base`=0x1000, immediate ack -> 16 writes at 0x1000..0x103C with data 0x01..0x10, 16 `r_ack` pulses, `wb_cyc_o` high for 31 cycles.
- Wait states: slave acks 3 cycles after each `wb_stb_o` -> ADR/DAT stable while waiting, exactly one `r_ack` per ack, no duplicated or skipped data.
- Frame wrap: FRAME_WORDS=32, `frame_base` changed from 0x1000 to 0x8000 during burst 2 -> `frame_done` pulse after ack 32, third burst starts at 0x8000.
- Enable: `enable` dropped in the middle of a burst -> the burst completes all 16 words and no new burst starts while `nb_pack_available`=1.
- Reset mid-burst: assert `nRST` after word 5 -> `wb_cyc_o`/`wb_stb_o` fall asynchronously, and the next burst restarts at `frame_base`.
